// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool stage behind the conv block.
// Splits each LENY-sample vector into POOL-sample windows. The vector can end
// with one shorter window. The signed maximum of each window goes into a
// 2-entry output FIFO. Each FIFO entry carries a flag that marks the last
// pooled sample of its vector.
module maxpool_stream #(
    parameter int WIDTH = 16,
    parameter int LENY  = 32,
    parameter int POOL  = 2,
    parameter int CNTW  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [WIDTH-1:0] m_data_out_z,
    output logic                    m_valid_z,
    input  logic                    m_ready_z,
    output logic                    m_last_z
);

    logic [CNTW-1:0]         win_cnt;
    logic [CNTW-1:0]         pos_cnt;
    logic signed [WIDTH-1:0] run_max;
    logic signed [WIDTH-1:0] win_val;
    logic signed [WIDTH-1:0] fifo_data [2];
    logic                    fifo_last [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic                    in_acc;
    logic                    out_acc;
    logic                    vec_end;
    logic                    win_end;
    logic                    push;

    // Ready depends only on the FIFO count. It has no path from m_ready_z.
    assign s_ready_y    = (count < 2'd2);
    assign m_valid_z    = (count != 2'd0);
    assign m_data_out_z = fifo_data[rd_ptr];
    assign m_last_z     = fifo_last[rd_ptr];

    assign in_acc  = s_valid_y && s_ready_y;
    assign out_acc = m_valid_z && m_ready_z;
    assign vec_end = (pos_cnt == CNTW'(LENY - 1));
    // A short trailing window closes early at the end of the vector.
    assign win_end = (win_cnt == CNTW'(POOL - 1)) || vec_end;
    assign push    = in_acc && win_end;

    // Window maximum including the current sample. Ties keep the stored value.
    always_comb begin
        win_val = run_max;
        if (win_cnt == '0) begin
            win_val = s_data_in_y;
        end else if (s_data_in_y > run_max) begin
            win_val = s_data_in_y;
        end
    end

    // Window/position counters and running maximum, advanced on input accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt <= '0;
            pos_cnt <= '0;
            run_max <= '0;
        end else if (in_acc) begin
            run_max <= win_val;
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            pos_cnt <= vec_end ? '0 : pos_cnt + 1'b1;
        end
    end

    // Two-entry output FIFO. A push and a pop in the same cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= win_val;
                fifo_last[wr_ptr] <= vec_end;
                wr_ptr            <= ~wr_ptr;
            end
            if (out_acc) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, out_acc})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream.
// Four instances with different LENY/POOL settings share one input stream.
// A queue-based window/FIFO model is checked against every instance on each
// falling edge. Literal checks pin the model to hand-computed results.
module tb_maxpool_stream;

    localparam int N = 4;
    localparam int LENY_T [N] = '{32, 5, 10, 4};
    localparam int POOL_T [N] = '{2, 2, 4, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b1;

    logic [15:0] z_data  [N];
    logic        z_valid [N];
    logic        z_last  [N];
    logic        z_ready [N];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state, one set per instance.
    int win_q [N][$];
    int pos_m [N];
    int eq_d  [N][$];
    int eq_l  [N][$];
    int log_d [N][$];
    int log_l [N][$];
    int lasts0 = 0;
    bit started = 1'b0;
    bit post_rst = 1'b0;

    always #5 clk = ~clk;

    maxpool_stream #(.WIDTH(16), .LENY(32), .POOL(2), .CNTW(6)) u_d0 (
        .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid),
        .s_ready_y(z_ready[0]), .m_data_out_z(z_data[0]), .m_valid_z(z_valid[0]),
        .m_ready_z(m_ready), .m_last_z(z_last[0]));
    maxpool_stream #(.WIDTH(16), .LENY(5), .POOL(2), .CNTW(3)) u_d1 (
        .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid),
        .s_ready_y(z_ready[1]), .m_data_out_z(z_data[1]), .m_valid_z(z_valid[1]),
        .m_ready_z(m_ready), .m_last_z(z_last[1]));
    maxpool_stream #(.WIDTH(16), .LENY(10), .POOL(4), .CNTW(4)) u_d2 (
        .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid),
        .s_ready_y(z_ready[2]), .m_data_out_z(z_data[2]), .m_valid_z(z_valid[2]),
        .m_ready_z(m_ready), .m_last_z(z_last[2]));
    maxpool_stream #(.WIDTH(16), .LENY(4), .POOL(1), .CNTW(3)) u_d3 (
        .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid),
        .s_ready_y(z_ready[3]), .m_data_out_z(z_data[3]), .m_valid_z(z_valid[3]),
        .m_ready_z(m_ready), .m_last_z(z_last[3]));

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Compare every instance with the model, then apply the handshakes of the coming edge.
    always @(negedge clk) begin
        int mx;
        int sv;
        for (int k = 0; k < N; k++) begin
            if (started) begin
                chk("s_ready", k, int'(z_ready[k]), int'(eq_d[k].size() < 2));
                chk("m_valid", k, int'(z_valid[k]), int'(eq_d[k].size() != 0));
                if (eq_d[k].size() != 0) begin
                    chk("m_data", k, int'($signed(z_data[k])), eq_d[k][0]);
                    chk("m_last", k, int'(z_last[k]), eq_l[k][0]);
                end else if (post_rst) begin
                    chk("rst_data", k, int'($signed(z_data[k])), 0);
                    chk("rst_last", k, int'(z_last[k]), 0);
                end
            end
            if (reset) begin
                win_q[k].delete();
                eq_d[k].delete();
                eq_l[k].delete();
                pos_m[k] = 0;
            end else if (started) begin
                if (z_valid[k] && m_ready) begin
                    log_d[k].push_back(int'($signed(z_data[k])));
                    log_l[k].push_back(int'(z_last[k]));
                    if (k == 0 && z_last[0]) lasts0++;
                    if (eq_d[k].size() != 0) begin
                        void'(eq_d[k].pop_front());
                        void'(eq_l[k].pop_front());
                    end
                end
                if (s_valid && z_ready[k]) begin
                    sv = int'($signed(s_data));
                    win_q[k].push_back(sv);
                    if (win_q[k].size() == POOL_T[k] || pos_m[k] == LENY_T[k] - 1) begin
                        mx = win_q[k][0];
                        for (int j = 1; j < win_q[k].size(); j++)
                            if (win_q[k][j] > mx) mx = win_q[k][j];
                        eq_d[k].push_back(mx);
                        eq_l[k].push_back(int'(pos_m[k] == LENY_T[k] - 1));
                        win_q[k].delete();
                    end
                    pos_m[k] = (pos_m[k] == LENY_T[k] - 1) ? 0 : pos_m[k] + 1;
                end
            end
        end
        if (reset) begin
            started  = 1'b1;
            post_rst = 1'b1;
        end else begin
            post_rst = 1'b0;
        end
    end

    task automatic step(input logic [15:0] d, input bit v, input bit r);
        s_data  = d;
        s_valid = v;
        m_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [15:0] pat(input int i);
        int v;
        case (i % 4)
            0:       v = 1 + i;
            1:       v = 4 + i;
            2:       v = -1 - i;
            default: v = -4 - i;
        endcase
        return 16'(v);
    endfunction

    initial begin
        int b;
        int cyc;
        int l0;
        logic [15:0] part [7];
        logic [15:0] pre  [7];
        logic [15:0] post [10];
        part = '{16'd3, 16'd9, 16'd4, 16'd2, 16'd8, 16'd6, 16'd1};
        pre  = '{16'd100, 16'd200, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90};
        post = '{-16'sd5, -16'sd2, -16'sd9, -16'sd1, 16'sd3, 16'sd4, 16'sd1, 16'sd2, 16'sd7, -16'sd8};

        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full vector with the output always ready, then two signed-compare windows.
        b = log_d[0].size();
        for (int i = 0; i < 32; i++) step(pat(i), 1'b1, 1'b1);
        step(16'hFFFF, 1'b1, 1'b1);
        step(16'h8000, 1'b1, 1'b1);
        step(16'h7FFF, 1'b1, 1'b1);
        step(16'h8000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h0, 1'b0, 1'b1);
        chk("vec_count", 0, log_d[0].size() - b, 18);
        if (log_d[0].size() >= b + 18) begin
            chk("z0", 0, log_d[0][b], 5);
            chk("z1", 0, log_d[0][b + 1], -3);
            chk("z2", 0, log_d[0][b + 2], 9);
            chk("z3", 0, log_d[0][b + 3], -7);
            chk("last14", 0, log_l[0][b + 14], 0);
            chk("last15", 0, log_l[0][b + 15], 1);
            chk("signed_neg", 0, log_d[0][b + 16], -1);
            chk("signed_pos", 0, log_d[0][b + 17], 32767);
        end

        // Partial trailing window on the LENY=5 instance.
        do_reset();
        b = log_d[1].size();
        for (int i = 0; i < 7; i++) step(part[i], 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h0, 1'b0, 1'b1);
        chk("part_count", 1, log_d[1].size() - b, 4);
        if (log_d[1].size() >= b + 4) begin
            chk("part_z0", 1, log_d[1][b], 9);
            chk("part_z1", 1, log_d[1][b + 1], 4);
            chk("part_z2", 1, log_d[1][b + 2], 8);
            chk("part_last1", 1, log_l[1][b + 1], 0);
            chk("part_last2", 1, log_l[1][b + 2], 1);
            chk("part_next", 1, log_d[1][b + 3], 6);
        end

        // Backpressure: hold the output for 10 cycles while input is offered.
        for (int i = 0; i < 10; i++) step(16'($urandom), 1'b1, 1'b0);
        chk("bp_ready", 0, int'(z_ready[0]), 0);
        chk("bp_valid", 0, int'(z_valid[0]), 1);
        for (int i = 0; i < 4; i++) step(16'h0, 1'b0, 1'b1);

        // Random valid/ready until 312 full vectors have left the first instance.
        do_reset();
        l0 = lasts0;
        cyc = 0;
        while (lasts0 - l0 < 312 && cyc < 60000) begin
            step(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc++;
        end
        chk("random_vectors", 0, lasts0 - l0, 312);
        for (int i = 0; i < 4; i++) step(16'h0, 1'b0, 1'b1);

        // Reset with one FIFO entry held and three samples of a POOL=4 window.
        do_reset();
        for (int i = 0; i < 7; i++) step(pre[i], 1'b1, 1'b0);
        chk("pre_valid", 2, int'(z_valid[2]), 1);
        reset = 1'b1;
        step(16'h0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rst_valid", 2, int'(z_valid[2]), 0);
        b = log_d[2].size();
        for (int i = 0; i < 10; i++) step(post[i], 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h0, 1'b0, 1'b1);
        chk("rst_count", 2, log_d[2].size() - b, 3);
        if (log_d[2].size() >= b + 3) begin
            chk("rst_z0", 2, log_d[2][b], -1);
            chk("rst_z1", 2, log_d[2][b + 1], 4);
            chk("rst_z2", 2, log_d[2][b + 2], 7);
            chk("rst_last2", 2, log_l[2][b + 2], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
